spi_slave_byte_if: RTL and testbench

//  SPI mode-0 slave front end; feeds the character automaton and returns its replies.

---
 rtl/spi_slave_byte_if.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front end: synchronises the SPI pins into clk, deframes MOSI
// into words and serialises replies from a one-deep holding register onto MISO.
module spi_slave_byte_if #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_underrun
);

    localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    // Synchronisers reset low so a frame already in progress at reset is never joined.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_n_d;

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_rise;
    logic cs_n_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_n_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_n_d    <= cs_n_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_n_rise = cs_n_s & ~cs_n_d;
    assign cs_n_fall = ~cs_n_s & cs_n_d;

    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-2:0]  rx_shift_q;
    logic               word_done_q;
    logic [DATA_W-1:0]  tx_shift_q;
    logic [DATA_W-1:0]  tx_shift_nxt;
    logic [DATA_W-1:0]  hold_q;
    logic               hold_full_q;
    logic               miso_q;
    logic               load_evt;
    logic               shift_evt;
    logic               bit_evt;
    logic               tx_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_DESEL;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Deselect takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_nxt = state_q;
        load_evt  = 1'b0;
        shift_evt = 1'b0;
        bit_evt   = 1'b0;
        case (state_q)
            WAIT_DESEL: begin
                if (cs_n_s) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (cs_n_fall) begin
                    state_nxt = ACTIVE;
                    load_evt  = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_n_rise) begin
                    state_nxt = IDLE;
                end else begin
                    bit_evt = sclk_rise;
                    if (sclk_fall) begin
                        if (bit_cnt_q == '0) begin
                            load_evt = 1'b1;
                        end else begin
                            shift_evt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = WAIT_DESEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            word_done_q <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            rx_valid    <= word_done_q;
            if (state_q != ACTIVE) begin
                bit_cnt_q <= '0;
            end else if (bit_evt) begin
                rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q   <= '0;
                    rx_data     <= {rx_shift_q, mosi_s};
                    word_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // A word accepted in the same cycle as a load event waits for the next one.
    assign tx_accept = tx_valid & ~hold_full_q;

    always_comb begin
        tx_shift_nxt = tx_shift_q;
        if (load_evt) begin
            tx_shift_nxt = hold_full_q ? hold_q : IDLE_WORD;
        end else if (shift_evt) begin
            tx_shift_nxt = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_underrun <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            tx_shift_q  <= tx_shift_nxt;
            tx_underrun <= load_evt & ~hold_full_q;
            miso_q      <= (state_nxt == ACTIVE) ? tx_shift_nxt[DATA_W-1] : 1'b0;
            if (load_evt && hold_full_q) begin
                hold_full_q <= 1'b0;
            end
            if (tx_accept) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign tx_ready = ~hold_full_q;
    assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed bench for spi_slave_byte_if: drives SPI mode-0 frames from tasks and
// checks received words, MISO replies and holding-register handshake.
module tb_spi_slave_byte_if;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_underrun;

    int         checks = 0;
    int         errors = 0;
    int         underrun_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    spi_slave_byte_if #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .IDLE_WORD   (8'hFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    // Every rx_valid pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) begin
            underrun_cnt++;
        end
        if (rx_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL rx_unexpected observed=0x%0h expected=none", rx_data);
            end else begin
                exp_v = exp_q.pop_front();
                assert (rx_data === exp_v) else begin
                    errors++;
                    $error("FAIL rx_word observed=0x%0h expected=0x%0h", rx_data, exp_v);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    // Shifts n bits MSB first; when last is set, CS_N rises with the final SCLK fall.
    task automatic spi_bits(input logic [7:0] v, input int n, input bit last,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = v[7-i];
            #HALF;
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
            if (last && i == n - 1) begin
                spi_cs_n = 1'b1;
            end
        end
    endtask

    task automatic offer(input logic [7:0] d, output bit acc);
        @(negedge clk);
        acc      = tx_ready;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        logic [7:0] m1;
        logic [7:0] m2;
        bit         acc;
        bit         got;
        int         u0;

        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;

        // 1: reset values, then a frame with no reply queued
        #23;
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_underrun", tx_underrun, 0);
        chk("rst_miso", spi_miso, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #200;
        u0 = underrun_cnt;
        exp_q.push_back(8'h33);
        frame_start();
        spi_bits(8'h33, 8, 1, m);
        #200;
        chk("t1_miso", m, 8'hFF);
        chk("t1_underrun", underrun_cnt - u0, 1);
        chk("t1_rx_data", rx_data, 8'h33);
        chk("t1_rx_drained", exp_q.size(), 0);

        // 2: queued reply 0xA5 goes out on the next frame
        chk("t2_ready_before", tx_ready, 1);
        offer(8'hA5, acc);
        chk("t2_accept", acc, 1);
        chk("t2_ready_held", tx_ready, 0);
        u0 = underrun_cnt;
        exp_q.push_back(8'h96);
        frame_start();
        chk("t2_ready_after_load", tx_ready, 1);
        spi_bits(8'h96, 8, 1, m);
        #200;
        chk("t2_miso", m, 8'hA5);
        chk("t2_underrun", underrun_cnt - u0, 0);
        chk("t2_rx_drained", exp_q.size(), 0);

        // 3: two words in one frame, reply written after the first rx_valid
        u0 = underrun_cnt;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h41);
        frame_start();
        fork
            begin
                spi_bits(8'h03, 8, 0, m1);
                spi_bits(8'h41, 8, 1, m2);
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 400 && !got; k++) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) got = 1'b1;
                end
                chk("t3_rx_seen", got, 1);
                offer(8'h62, acc);
                chk("t3_accept", acc, 1);
            end
        join
        #200;
        chk("t3_miso_first", m1, 8'hFF);
        chk("t3_miso_second", m2, 8'h62);
        chk("t3_underrun", underrun_cnt - u0, 1);
        chk("t3_rx_data", rx_data, 8'h41);
        chk("t3_rx_drained", exp_q.size(), 0);

        // 4: partial word is dropped, next frame is clean
        frame_start();
        spi_bits(8'hB0, 5, 1, m);
        #200;
        chk("t4_rx_data_held", rx_data, 8'h41);
        exp_q.push_back(8'h5A);
        frame_start();
        spi_bits(8'h5A, 8, 1, m);
        #200;
        chk("t4_rx_data", rx_data, 8'h5A);
        chk("t4_rx_drained", exp_q.size(), 0);

        // 5: reset mid-word with CS_N held low
        frame_start();
        spi_bits(8'hE0, 3, 0, m);
        rst_n = 1'b0;
        #20;
        chk("t5_rst_rx_data", rx_data, 0);
        chk("t5_rst_tx_ready", tx_ready, 1);
        chk("t5_rst_miso", spi_miso, 0);
        @(negedge clk);
        rst_n = 1'b1;
        u0 = underrun_cnt;
        spi_bits(8'hAA, 8, 0, m);
        #200;
        chk("t5_miso_quiet", m, 0);
        chk("t5_underrun", underrun_cnt - u0, 0);
        chk("t5_rx_data_quiet", rx_data, 0);
        spi_cs_n = 1'b1;
        #200;
        exp_q.push_back(8'hC3);
        frame_start();
        spi_bits(8'hC3, 8, 1, m);
        #200;
        chk("t5_rx_data", rx_data, 8'hC3);
        chk("t5_rx_drained", exp_q.size(), 0);

        // 6: offer while full is ignored
        offer(8'h22, acc);
        chk("t6_accept_first", acc, 1);
        offer(8'h11, acc);
        chk("t6_reject_second", acc, 0);
        chk("t6_ready_low", tx_ready, 0);
        u0 = underrun_cnt;
        exp_q.push_back(8'h7E);
        frame_start();
        spi_bits(8'h7E, 8, 1, m);
        #200;
        chk("t6_miso", m, 8'h22);
        chk("t6_underrun", underrun_cnt - u0, 0);
        chk("t6_ready_after", tx_ready, 1);
        chk("t6_rx_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
